// File: rtl/hex_event_display.sv
// hex_event_display: drives NUM_DIGITS active-low 7-segment digits with either the name of a
// single pressed N8 button or a maze event message. Event messages are edge-triggered,
// prioritised (complete > gameover > tpblks > startblk), held for at least HOLD_CYCLES and
// scrolled when longer than the display.
//
// Ports:
//   i_clk      system clock, all state changes on the rising edge
//   i_reset    synchronous active-low reset
//   i_btn      {right,left,up,down,select,start,a,b}, level, 1 = pressed
//   i_evt      {complete,gameover,tpblks,startblk}, level
//   o_hex      o_hex[7k+6:7k] = HEXk (HEX0 rightmost), active-low, bit0 = segment a
//   o_msg_id   ID of the message currently displayed
//   o_evt_busy 1 while an event message is displayed, held or pending
module hex_event_display #(
    parameter int unsigned NUM_DIGITS    = 6,
    parameter int unsigned HOLD_CYCLES   = 50000000,
    parameter int unsigned SCROLL_CYCLES = 12500000,
    parameter int unsigned CNT_W         = 26
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [7:0]              i_btn,
    input  logic [3:0]              i_evt,
    output logic [7*NUM_DIGITS-1:0] o_hex,
    output logic [3:0]              o_msg_id,
    output logic                    o_evt_busy
);

    localparam int ND = int'(NUM_DIGITS);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SCROLL_LAST = CNT_W'(SCROLL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    // Active-low glyphs, bit0 = segment a
    localparam logic [6:0] G_BL = 7'h7F;
    localparam logic [6:0] G_A  = 7'h08;
    localparam logic [6:0] G_B  = 7'h03;
    localparam logic [6:0] G_C  = 7'h46;
    localparam logic [6:0] G_D  = 7'h21;
    localparam logic [6:0] G_E  = 7'h06;
    localparam logic [6:0] G_I  = 7'h79;
    localparam logic [6:0] G_L  = 7'h47;
    localparam logic [6:0] G_O  = 7'h40;
    localparam logic [6:0] G_P  = 7'h0C;
    localparam logic [6:0] G_R  = 7'h2F;
    localparam logic [6:0] G_S  = 7'h12;
    localparam logic [6:0] G_T  = 7'h07;
    localparam logic [6:0] G_U  = 7'h41;

    typedef enum logic [1:0] {StIdle, StBtn, StEvt, StScroll} state_e;

    // Message text, element 0 = leftmost character
    function automatic logic [0:7][6:0] msg_text(input logic [3:0] id);
        logic [0:7][6:0] t;
        t = {8{G_BL}};
        case (id)
            4'd1:    t = {G_U, G_P, {6{G_BL}}};
            4'd2:    t = {G_D, G_O, {6{G_BL}}};
            4'd3:    t = {G_L, G_E, {6{G_BL}}};
            4'd4:    t = {G_R, G_I, {6{G_BL}}};
            4'd5:    t = {G_S, G_E, {6{G_BL}}};
            4'd6:    t = {G_S, G_T, {6{G_BL}}};
            4'd7:    t = {G_A, {7{G_BL}}};
            4'd8:    t = {G_B, {7{G_BL}}};
            4'd9:    t = {G_S, G_T, G_A, G_R, G_T, {3{G_BL}}};
            4'd10:   t = {G_T, G_E, G_L, G_E, G_P, G_O, G_R, G_T};
            4'd11:   t = {G_D, G_E, G_A, G_D, {4{G_BL}}};
            4'd12:   t = {G_C, G_L, G_E, G_A, G_R, {3{G_BL}}};
            default: t = {8{G_BL}};
        endcase
        return t;
    endfunction

    function automatic logic [3:0] msg_len(input logic [3:0] id);
        logic [3:0] l;
        case (id)
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: l = 4'd2;
            4'd7, 4'd8:                         l = 4'd1;
            4'd9, 4'd12:                        l = 4'd5;
            4'd10:                              l = 4'd8;
            4'd11:                              l = 4'd4;
            default:                            l = 4'd0;
        endcase
        return l;
    endfunction

    state_e                  r_state, w_state_d;
    logic [3:0]              r_msg, w_msg_d;
    logic [1:0]              r_cur, w_cur_d;
    logic [3:0]              r_pend, w_pend_d;
    logic [3:0]              r_prev;
    logic [CNT_W-1:0]        r_hold, w_hold_d;
    logic [CNT_W-1:0]        r_scnt, w_scnt_d;
    logic [3:0]              r_off, w_off_d;
    logic [7*NUM_DIGITS-1:0] r_hex, w_hex_d;
    logic                    r_busy, w_busy_d;

    logic [3:0]      w_pend;
    logic [1:0]      w_top;
    logic            w_top_long;
    logic            w_btn_one;
    logic [3:0]      w_btn_msg;
    logic            w_take;
    logic            w_release;
    int              w_len_d;
    logic [0:7][6:0] w_text;

    // Pending set includes this cycle's rising edges so events show on the sampling edge
    assign w_pend    = r_pend | (i_evt & ~r_prev);
    assign w_btn_one = $onehot(i_btn);
    assign w_top_long = int'(msg_len(4'd9 + {2'b00, w_top})) > ND;
    assign w_len_d   = int'(msg_len(w_msg_d));

    always_comb begin
        w_top = 2'd0;
        if (w_pend[3])      w_top = 2'd3;
        else if (w_pend[2]) w_top = 2'd2;
        else if (w_pend[1]) w_top = 2'd1;
    end

    always_comb begin
        w_btn_msg = 4'd0;
        case (i_btn)
            8'h80:   w_btn_msg = 4'd4;
            8'h40:   w_btn_msg = 4'd3;
            8'h20:   w_btn_msg = 4'd1;
            8'h10:   w_btn_msg = 4'd2;
            8'h08:   w_btn_msg = 4'd5;
            8'h04:   w_btn_msg = 4'd6;
            8'h02:   w_btn_msg = 4'd7;
            8'h01:   w_btn_msg = 4'd8;
            default: w_btn_msg = 4'd0;
        endcase
    end

    always_comb begin
        w_state_d = r_state;
        w_msg_d   = r_msg;
        w_cur_d   = r_cur;
        w_pend_d  = w_pend;
        w_hold_d  = (r_hold != '0) ? r_hold - CNT_ONE : '0;
        w_take    = 1'b0;
        w_release = 1'b0;
        unique case (r_state)
            StIdle, StBtn: begin
                if (|w_pend) w_take = 1'b1;
                else         w_release = 1'b1;
            end
            StEvt, StScroll: begin
                // Strictly higher priority preempts; equal/lower waits for the hold to expire
                if ((|w_pend) && (w_top > r_cur)) begin
                    w_take = 1'b1;
                end else if ((r_hold == '0) && !i_evt[r_cur]) begin
                    if (|w_pend) w_take = 1'b1;
                    else         w_release = 1'b1;
                end
            end
        endcase
        if (w_take) begin
            w_cur_d          = w_top;
            w_msg_d          = 4'd9 + {2'b00, w_top};
            w_pend_d[w_top]  = 1'b0;
            w_hold_d         = HOLD_LOAD;
            w_state_d        = w_top_long ? StScroll : StEvt;
        end else if (w_release) begin
            w_state_d = w_btn_one ? StBtn : StIdle;
            w_msg_d   = w_btn_msg;
        end
    end

    // Scroll position restarts whenever a new event message is loaded
    always_comb begin
        w_scnt_d = '0;
        w_off_d  = '0;
        if ((w_state_d == StScroll) && !w_take) begin
            if (r_scnt == SCROLL_LAST) begin
                w_off_d = (int'(r_off) == w_len_d + 1) ? 4'd0 : r_off + 4'd1;
            end else begin
                w_scnt_d = r_scnt + CNT_ONE;
                w_off_d  = r_off;
            end
        end
    end

    assign w_busy_d = (w_state_d == StEvt) || (w_state_d == StScroll) || (|w_pend_d);
    assign w_text   = msg_text(w_msg_d);

    // Right-aligned static text, or a window onto the ring "text + 2 blanks" when scrolling
    always_comb begin
        int p;
        int idx;
        w_hex_d = '1;
        for (int k = 0; k < ND; k++) begin
            p = ND - 1 - k;
            if (w_state_d == StScroll) begin
                idx = int'(w_off_d) + p;
                if (idx >= w_len_d + 2) idx = idx - (w_len_d + 2);
            end else begin
                idx = p - (ND - w_len_d);
            end
            if ((idx >= 0) && (idx < w_len_d)) w_hex_d[7*k +: 7] = w_text[idx[2:0]];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= StIdle;
            r_msg   <= 4'd0;
            r_cur   <= 2'd0;
            r_pend  <= 4'd0;
            r_prev  <= 4'd0;
            r_hold  <= '0;
            r_scnt  <= '0;
            r_off   <= 4'd0;
            r_hex   <= '1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_msg   <= w_msg_d;
            r_cur   <= w_cur_d;
            r_pend  <= w_pend_d;
            r_prev  <= i_evt;
            r_hold  <= w_hold_d;
            r_scnt  <= w_scnt_d;
            r_off   <= w_off_d;
            r_hex   <= w_hex_d;
            r_busy  <= w_busy_d;
        end
    end

    assign o_hex      = r_hex;
    assign o_msg_id   = r_msg;
    assign o_evt_busy = r_busy;

endmodule
